// File: rtl/niosii_system_sysinfo_qsys.sv
// Avalon-MM system-information slave: ID, build timestamp, uptime counter with coherent 64-bit read, scratch bank.
// Reads return one cycle after acceptance; every strobe is accepted immediately (no waitrequest).
module niosii_system_sysinfo_qsys #(
  parameter logic [31:0] SYSTEM_ID     = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP     = 32'h0000_0000,
  parameter int unsigned UPTIME_W      = 48,
  parameter int unsigned SCRATCH_WORDS = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam logic [2:0] ADDR_ID    = 3'd0;
  localparam logic [2:0] ADDR_TS    = 3'd1;
  localparam logic [2:0] ADDR_UPLO  = 3'd2;
  localparam logic [2:0] ADDR_UPHI  = 3'd3;
  localparam logic [2:0] ADDR_CTRL  = 3'd4;
  localparam int unsigned ADDR_SCR0 = 5;

  localparam logic [UPTIME_W-1:0] UP_ONE = 1;

  logic [UPTIME_W-1:0] r_uptime;
  logic [31:0]         r_shadow;
  logic                r_freeze;
  logic [31:0]         r_scratch [SCRATCH_WORDS];
  logic [31:0]         r_readdata;
  logic                r_readdatavalid;

  logic        w_wr_acc;
  logic        w_ctrl_wr;
  logic        w_clear;
  logic        w_uplo_rd;
  logic [31:0] w_up_hi;
  logic [31:0] w_rdata;

  // A simultaneous read wins; the write is silently dropped.
  assign w_wr_acc  = write & ~read;
  assign w_ctrl_wr = w_wr_acc & (address == ADDR_CTRL) & byteenable[0];
  assign w_clear   = w_ctrl_wr & writedata[1];
  assign w_uplo_rd = read & (address == ADDR_UPLO);
  assign w_up_hi   = 32'(r_uptime >> 32);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_uptime <= '0;
    end else if (w_clear) begin
      r_uptime <= '0;
    end else if (!r_freeze) begin
      r_uptime <= r_uptime + UP_ONE;
    end
  end

  // High half is captured with the low-word read so a later word-3 read cannot tear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow <= '0;
    end else if (w_uplo_rd) begin
      r_shadow <= w_up_hi;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_freeze <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_freeze <= writedata[0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SCRATCH_WORDS; i++) begin
        r_scratch[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SCRATCH_WORDS; i++) begin
        for (int b = 0; b < 4; b++) begin
          if (w_wr_acc && (address == 3'(ADDR_SCR0 + i)) && byteenable[b]) begin
            r_scratch[i][8*b +: 8] <= writedata[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_ID:   w_rdata = SYSTEM_ID;
      ADDR_TS:   w_rdata = TIMESTAMP;
      ADDR_UPLO: w_rdata = r_uptime[31:0];
      ADDR_UPHI: w_rdata = r_shadow;
      ADDR_CTRL: w_rdata = {31'd0, r_freeze};
      default: begin
        for (int i = 0; i < SCRATCH_WORDS; i++) begin
          if (address == 3'(ADDR_SCR0 + i)) begin
            w_rdata = r_scratch[i];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata      <= '0;
      r_readdatavalid <= 1'b0;
    end else begin
      r_readdatavalid <= read;
      if (read) begin
        r_readdata <= w_rdata;
      end
    end
  end

  assign readdata      = r_readdata;
  assign readdatavalid = r_readdatavalid;

endmodule

// File: tb/tb_niosii_system_sysinfo_qsys.sv
// Directed bench for the system-information slave: register table plus uptime, wrap and reset sequences.
module tb_niosii_system_sysinfo_qsys;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  int checks = 0;
  int errors = 0;

  niosii_system_sysinfo_qsys #(
    .SYSTEM_ID    (32'h5AD0_0001),
    .TIMESTAMP    (32'd1490233400),
    .UPTIME_W     (48),
    .SCRATCH_WORDS(2)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .byteenable   (byteenable),
    .readdata     (readdata),
    .readdatavalid(readdatavalid)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clock);
    address = a; writedata = d; byteenable = be; write = 1'b1;
    @(posedge clock);
    #1;
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clock);
    address = a; read = 1'b1;
    @(posedge clock);
    #1;
    read = 1'b0;
    check("rd_valid", {31'd0, readdatavalid}, 32'd1);
    d = readdata;
  endtask

  typedef struct {
    bit          wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [18];
  logic [31:0] rexp [8];
  logic [31:0] v, v1, v2;

  initial begin
    tbl[0]  = '{1'b1, 3'd5, 32'hDEAD_BEEF, 4'hF,     32'h0};
    tbl[1]  = '{1'b1, 3'd5, 32'h1234_5678, 4'b0101,  32'h0};
    tbl[2]  = '{1'b0, 3'd5, 32'h0,         4'h0,     32'hDE34_BE78};
    tbl[3]  = '{1'b1, 3'd6, 32'hA5A5_0F0F, 4'b1010,  32'h0};
    tbl[4]  = '{1'b0, 3'd6, 32'h0,         4'h0,     32'hA500_0F00};
    tbl[5]  = '{1'b1, 3'd0, 32'hFFFF_FFFF, 4'hF,     32'h0};
    tbl[6]  = '{1'b0, 3'd0, 32'h0,         4'h0,     32'h5AD0_0001};
    tbl[7]  = '{1'b1, 3'd1, 32'h0,         4'hF,     32'h0};
    tbl[8]  = '{1'b0, 3'd1, 32'h0,         4'h0,     32'd1490233400};
    tbl[9]  = '{1'b1, 3'd7, 32'hFFFF_FFFF, 4'hF,     32'h0};
    tbl[10] = '{1'b0, 3'd7, 32'h0,         4'h0,     32'h0};
    tbl[11] = '{1'b1, 3'd4, 32'hFFFF_FF01, 4'b1110,  32'h0};
    tbl[12] = '{1'b0, 3'd4, 32'h0,         4'h0,     32'h0};
    tbl[13] = '{1'b1, 3'd4, 32'hFFFF_FFFD, 4'hF,     32'h0};
    tbl[14] = '{1'b0, 3'd4, 32'h0,         4'h0,     32'h1};
    tbl[15] = '{1'b1, 3'd4, 32'h0,         4'hF,     32'h0};
    tbl[16] = '{1'b0, 3'd4, 32'h0,         4'h0,     32'h0};
    tbl[17] = '{1'b0, 3'd5, 32'h0,         4'h0,     32'hDE34_BE78};

    rexp[0] = 32'h5AD0_0001; rexp[1] = 32'd1490233400; rexp[2] = 32'd2; rexp[3] = 32'h0;
    rexp[4] = 32'h0;         rexp[5] = 32'h0;          rexp[6] = 32'h0; rexp[7] = 32'h0;

    // Reset state, then back-to-back reads of the whole map starting on the first edge.
    #22;
    check("reset_readdata", readdata, 32'h0);
    check("reset_valid", {31'd0, readdatavalid}, 32'd0);
    for (int a = 0; a < 8; a++) begin
      @(negedge clock);
      if (a == 0) reset_n = 1'b1;
      address = 3'(a); read = 1'b1;
      @(posedge clock);
      #1;
      check($sformatf("init_valid_w%0d", a), {31'd0, readdatavalid}, 32'd1);
      check($sformatf("init_data_w%0d", a), readdata, rexp[a]);
    end
    @(negedge clock);
    read = 1'b0;
    @(posedge clock);
    #1;
    check("valid_drops", {31'd0, readdatavalid}, 32'd0);

    // Simultaneous read and write: read served with old data, write dropped.
    @(negedge clock);
    address = 3'd6; read = 1'b1; write = 1'b1; writedata = 32'hFFFF_FFFF; byteenable = 4'hF;
    @(posedge clock);
    #1;
    read = 1'b0; write = 1'b0;
    check("rw_valid", {31'd0, readdatavalid}, 32'd1);
    check("rw_old_data", readdata, 32'h0);
    bus_read(3'd6, v);
    check("rw_write_dropped", v, 32'h0);

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].wr) begin
        bus_write(tbl[i].addr, tbl[i].wdata, tbl[i].be);
      end else begin
        bus_read(tbl[i].addr, v);
        check($sformatf("vec%0d_w%0d", i, tbl[i].addr), v, tbl[i].exp);
      end
    end

    repeat (2) @(posedge clock);
    #1;
    check("hold_data", readdata, 32'hDE34_BE78);
    check("hold_valid", {31'd0, readdatavalid}, 32'd0);

    // Freeze, clear, and restart of the uptime counter.
    bus_write(3'd4, 32'h1, 4'hF);
    bus_read(3'd2, v1);
    repeat (10) @(posedge clock);
    bus_read(3'd2, v2);
    check("freeze_equal", v2, v1);
    bus_write(3'd4, 32'h2, 4'hF);
    bus_read(3'd2, v);
    check("clear_zero", v, 32'h0);
    bus_write(3'd4, 32'h3, 4'hF);
    bus_read(3'd2, v);
    check("clear_frozen_a", v, 32'h0);
    repeat (5) @(posedge clock);
    bus_read(3'd2, v);
    check("clear_frozen_b", v, 32'h0);
    bus_write(3'd4, 32'h0, 4'hF);
    repeat (3) @(posedge clock);
    bus_read(3'd2, v);
    check("restart_nonzero", {31'd0, (v != 32'h0)}, 32'd1);
    check("restart_count", v, 32'd3);

    // Coherent read across the 32-bit wrap, counter preset while frozen.
    bus_write(3'd4, 32'h1, 4'hF);
    @(negedge clock);
    force dut.r_uptime = 48'h0000_FFFF_FFFE;
    @(negedge clock);
    release dut.r_uptime;
    bus_read(3'd2, v);
    check("wrap_low", v, 32'hFFFF_FFFE);
    bus_write(3'd4, 32'h0, 4'hF);
    repeat (5) @(posedge clock);
    bus_read(3'd3, v);
    check("wrap_high_shadow", v, 32'h0);
    bus_read(3'd2, v);
    check("wrap_low_after", v, 32'h4);
    bus_read(3'd3, v);
    check("wrap_high_after", v, 32'h1);

    // Reset lands on the edge that would accept an outstanding read.
    @(negedge clock);
    address = 3'd5; read = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_data", readdata, 32'h0);
    check("rst_async_valid", {31'd0, readdatavalid}, 32'd0);
    @(posedge clock);
    #1;
    check("rst_no_pulse", {31'd0, readdatavalid}, 32'd0);
    @(negedge clock);
    read = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    address = 3'd2; read = 1'b1;
    @(posedge clock);
    #1;
    read = 1'b0;
    check("rst_restart_valid", {31'd0, readdatavalid}, 32'd1);
    check("rst_restart_count", readdata, 32'h0);
    bus_read(3'd3, v);
    check("rst_shadow", v, 32'h0);
    bus_read(3'd4, v);
    check("rst_ctrl", v, 32'h0);
    bus_read(3'd5, v);
    check("rst_scratch5", v, 32'h0);
    bus_read(3'd6, v);
    check("rst_scratch6", v, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
